// File: rtl/sram_arbiter_if.sv
// Bundle of the two requester ports and the SRAM pin group.
// The arbiter connects through the slave modport; the requester/SRAM side uses master.
interface sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_dout;
    logic [DATA_W-1:0] sram_din;
    logic              sram_doe, sram_wen, sram_oen, sram_cen;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_din,
        output ack0, ack1, rdata0, rdata1,
        output sram_addr, sram_dout, sram_doe, sram_wen, sram_oen, sram_cen
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_din,
        input  ack0, ack1, rdata0, rdata1,
        input  sram_addr, sram_dout, sram_doe, sram_wen, sram_oen, sram_cen
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for an asynchronous SRAM with programmable
// read wait and write pulse width; every SRAM/ack output decodes registered state.
module sram_arbiter #(
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic           clk,
    input  logic           reset,
    sram_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        READ,
        WSETUP,
        WPULSE,
        WHOLD,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       gnt;
    logic       last_grant;
    logic       pick;
    logic       grant_en;
    logic       capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            gnt           <= 1'b0;
            last_grant    <= 1'b1;
            bus.sram_addr <= '0;
            bus.sram_dout <= '0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Address and data are frozen at grant so requester changes cannot leak in.
            if (grant_en) begin
                gnt           <= pick;
                last_grant    <= pick;
                bus.sram_addr <= pick ? bus.addr1  : bus.addr0;
                bus.sram_dout <= pick ? bus.wdata1 : bus.wdata0;
            end
            if (capture) begin
                if (gnt) bus.rdata1 <= bus.sram_din;
                else     bus.rdata0 <= bus.sram_din;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_en  = 1'b0;
        capture   = 1'b0;
        // On contention the port that did not win last time goes first.
        if (bus.req0 && bus.req1) pick = ~last_grant;
        else                      pick = bus.req1;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant_en  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = (pick ? bus.we1 : bus.we0) ? WSETUP : READ;
                end
            end
            READ: begin
                if (cnt == 3'(RD_WAIT)) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                end
            end
            WSETUP: begin
                cnt_nxt   = '0;
                state_nxt = WPULSE;
            end
            WPULSE: begin
                if (cnt == 3'(WR_PULSE - 1)) state_nxt = WHOLD;
                else                         cnt_nxt   = cnt + 3'd1;
            end
            WHOLD:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.sram_cen = !(state inside {READ, WSETUP, WPULSE, WHOLD});
    assign bus.sram_oen = (state != READ);
    assign bus.sram_wen = (state != WPULSE);
    assign bus.sram_doe = (state inside {WSETUP, WPULSE, WHOLD});
    assign bus.ack0     = (state == DONE) && !gnt;
    assign bus.ack1     = (state == DONE) &&  gnt;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: two instances (default timing and RD_WAIT=3/WR_PULSE=2),
// a behavioural SRAM, directed vector table, hand-written corner sequences and random traffic.
module tb_sram_arbiter;
    localparam int RD_B = 3;
    localparam int WR_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_v;
    logic [1:0]       req0_v, req1_v, we0_v, we1_v;
    logic [1:0][17:0] addr0_v, addr1_v;
    logic [1:0][15:0] wdata0_v, wdata1_v, din_v;
    logic [1:0]       ack0_v, ack1_v, doe_v, wen_v, oen_v, cen_v;
    logic [1:0][15:0] rdata0_v, rdata1_v, dout_v;
    logic [1:0][17:0] saddr_v;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_arbiter_if bus ();
        assign bus.req0     = req0_v[g];
        assign bus.req1     = req1_v[g];
        assign bus.we0      = we0_v[g];
        assign bus.we1      = we1_v[g];
        assign bus.addr0    = addr0_v[g];
        assign bus.addr1    = addr1_v[g];
        assign bus.wdata0   = wdata0_v[g];
        assign bus.wdata1   = wdata1_v[g];
        assign bus.sram_din = din_v[g];
        assign ack0_v[g]    = bus.ack0;
        assign ack1_v[g]    = bus.ack1;
        assign rdata0_v[g]  = bus.rdata0;
        assign rdata1_v[g]  = bus.rdata1;
        assign saddr_v[g]   = bus.sram_addr;
        assign dout_v[g]    = bus.sram_dout;
        assign doe_v[g]     = bus.sram_doe;
        assign wen_v[g]     = bus.sram_wen;
        assign oen_v[g]     = bus.sram_oen;
        assign cen_v[g]     = bus.sram_cen;
        sram_arbiter #(
            .RD_WAIT (g == 0 ? 1 : RD_B),
            .WR_PULSE(g == 0 ? 1 : WR_B)
        ) dut (
            .clk  (clk),
            .reset(rst_v[g]),
            .bus  (bus.slave)
        );
    end

    // SRAM contents for both instances, keyed by instance and address
    logic [15:0] mem     [int];
    logic [15:0] ref_mem [int];
    int          proto_bad = 0;

    function automatic int key(int d, logic [17:0] a);
        return d * 262144 + int'(a);
    endfunction

    function automatic logic [15:0] dflt(logic [17:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] mem_rd(int d, logic [17:0] a);
        int k = key(d, a);
        return mem.exists(k) ? mem[k] : dflt(a);
    endfunction

    function automatic logic [15:0] ref_rd(int d, logic [17:0] a);
        int k = key(d, a);
        return ref_mem.exists(k) ? ref_mem[k] : dflt(a);
    endfunction

    always @(posedge clk)
        for (int g = 0; g < 2; g++)
            if (wen_v[g] === 1'b0) mem[key(g, saddr_v[g])] = dout_v[g];

    always @(negedge clk)
        for (int g = 0; g < 2; g++)
            din_v[g] = (oen_v[g] === 1'b0) ? mem_rd(g, saddr_v[g]) : 16'hDEAD;

    always @(negedge clk)
        for (int g = 0; g < 2; g++)
            if ((wen_v[g] === 1'b0 && oen_v[g] === 1'b0) ||
                (doe_v[g] === 1'b1 && oen_v[g] === 1'b0) ||
                (wen_v[g] === 1'b0 && doe_v[g] !== 1'b1))
                proto_bad++;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d, int p, logic r, logic w, logic [17:0] a, logic [15:0] wd);
        if (p == 0) begin
            req0_v[d] = r; we0_v[d] = w; addr0_v[d] = a; wdata0_v[d] = wd;
        end else begin
            req1_v[d] = r; we1_v[d] = w; addr1_v[d] = a; wdata1_v[d] = wd;
        end
    endtask

    task automatic set_req(int d, int p, logic r);
        if (p == 0) req0_v[d] = r;
        else        req1_v[d] = r;
    endtask

    function automatic logic ack_of(int d, int p);
        return (p == 0) ? ack0_v[d] : ack1_v[d];
    endfunction

    function automatic logic [15:0] rd_of(int d, int p);
        return (p == 0) ? rdata0_v[d] : rdata1_v[d];
    endfunction

    task automatic do_reset(bit chk);
        rst_v  = 2'b11;
        req0_v = '0;
        req1_v = '0;
        tick();
        tick();
        if (chk) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("rst%0d_ctl", d), {cen_v[d], oen_v[d], wen_v[d], doe_v[d]}, 4'b1110);
                check($sformatf("rst%0d_ack", d), {ack0_v[d], ack1_v[d]}, 2'b00);
                check($sformatf("rst%0d_rdata", d), {rdata0_v[d], rdata1_v[d]}, 32'h0);
                check($sformatf("rst%0d_bus", d), {saddr_v[d], dout_v[d]}, 34'h0);
            end
        end
        rst_v = 2'b00;
    endtask

    typedef struct {
        int          d;
        int          p;
        logic        we;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic        pre;
        logic [15:0] pre_val;
        int          lat;
        logic [15:0] rdata;
        logic [7:0]  oen_m;   // bit k: sram_oen low in cycle k
        logic [7:0]  wen_m;   // bit k: sram_wen low in cycle k
        logic [7:0]  doe_m;   // bit k: sram_doe high in cycle k
        logic [7:0]  cen_m;   // bit k: sram_cen low in cycle k
    } vec_t;

    // Called at the start of an IDLE cycle; leaves the arbiter in IDLE again.
    task automatic run_vec(vec_t v, string nm);
        int          o   = 1 - v.p;
        logic [15:0] oth = rd_of(v.d, o);
        logic [7:0]  om = '0, wm = '0, dm = '0, cm = '0;
        int          lat  = -1;
        logic        oack = 1'b0;
        if (v.pre) mem[key(v.d, v.addr)] = v.pre_val;
        drive(v.d, v.p, 1'b1, v.we, v.addr, v.wdata);
        for (int k = 0; k <= 12 && lat < 0; k++) begin
            if (k > 0) tick();
            if (k < 8) begin
                om[k] = !oen_v[v.d];
                wm[k] = !wen_v[v.d];
                dm[k] = doe_v[v.d];
                cm[k] = !cen_v[v.d];
            end
            oack |= ack_of(v.d, o);
            if (ack_of(v.d, v.p)) lat = k;
        end
        set_req(v.d, v.p, 1'b0);
        check({nm, "_lat"}, lat, v.lat);
        check({nm, "_oen"}, om, v.oen_m);
        check({nm, "_wen"}, wm, v.wen_m);
        check({nm, "_doe"}, dm, v.doe_m);
        check({nm, "_cen"}, cm, v.cen_m);
        check({nm, "_other_ack"}, oack, 1'b0);
        check({nm, "_other_rdata"}, rd_of(v.d, o), oth);
        if (v.we) check({nm, "_mem"}, mem_rd(v.d, v.addr), v.wdata);
        else      check({nm, "_rdata"}, rd_of(v.d, v.p), v.rdata);
        tick();
        check({nm, "_ack_pulse"}, ack_of(v.d, v.p), 1'b0);
    endtask

    // Random-phase reference state
    int          idle_at[2], ack_at[2], own[2], last_g[2];
    bit          busy[2];
    bit          pend[2][2];
    logic        pwe[2][2];
    logic [17:0] paddr[2][2];
    logic [15:0] pdata[2][2];
    logic        m_we[2];
    logic [17:0] m_addr[2];
    logic [15:0] m_data[2];
    logic [15:0] exp_rd[2][2];

    initial begin
        vec_t vt[$];
        vec_t vr;
        int   lat, na, bad, pk;
        logic oack, e0, e1, done;

        rst_v    = 2'b11;
        req0_v   = '0; req1_v   = '0; we0_v    = '0; we1_v    = '0;
        addr0_v  = '0; addr1_v  = '0; wdata0_v = '0; wdata1_v = '0;
        do_reset(1'b1);

        //                d  p  we  addr       wdata     pre  pre_val  lat rdata     oen    wen    doe    cen
        vt.push_back(vec_t'{0, 0, 0, 18'h00010, 16'h0000, 1, 16'hBEEF, 3, 16'hBEEF, 8'h06, 8'h00, 8'h00, 8'h06});
        vt.push_back(vec_t'{0, 1, 1, 18'h3FFFF, 16'h1234, 0, 16'h0000, 4, 16'h0000, 8'h00, 8'h04, 8'h0E, 8'h0E});
        vt.push_back(vec_t'{0, 1, 0, 18'h3FFFF, 16'h0000, 0, 16'h0000, 3, 16'h1234, 8'h06, 8'h00, 8'h00, 8'h06});
        vt.push_back(vec_t'{0, 0, 1, 18'h00000, 16'hFFFF, 0, 16'h0000, 4, 16'h0000, 8'h00, 8'h04, 8'h0E, 8'h0E});
        vt.push_back(vec_t'{0, 0, 0, 18'h00000, 16'h0000, 0, 16'h0000, 3, 16'hFFFF, 8'h06, 8'h00, 8'h00, 8'h06});
        vt.push_back(vec_t'{0, 1, 0, 18'h12345, 16'h0000, 1, 16'h0000, 3, 16'h0000, 8'h06, 8'h00, 8'h00, 8'h06});
        vt.push_back(vec_t'{1, 0, 0, 18'h00100, 16'h0000, 1, 16'hCAFE, 5, 16'hCAFE, 8'h1E, 8'h00, 8'h00, 8'h1E});
        vt.push_back(vec_t'{1, 1, 1, 18'h00200, 16'h7777, 0, 16'h0000, 5, 16'h0000, 8'h00, 8'h0C, 8'h1E, 8'h1E});
        vt.push_back(vec_t'{1, 0, 0, 18'h00200, 16'h0000, 0, 16'h0000, 5, 16'h7777, 8'h1E, 8'h00, 8'h00, 8'h1E});
        foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

        // Continuous contention after reset: grants alternate starting with port 0
        do_reset(1'b1);
        drive(0, 0, 1'b1, 1'b0, 18'h00040, 16'h0);
        drive(0, 1, 1'b1, 1'b0, 18'h00041, 16'h0);
        na = 0;
        for (int k = 1; k <= 24 && na < 4; k++) begin
            tick();
            if (ack0_v[0] || ack1_v[0]) begin
                check($sformatf("contend%0d_port", na), {ack0_v[0], ack1_v[0]}, (na % 2 == 0) ? 2'b10 : 2'b01);
                check($sformatf("contend%0d_cycle", na), k, 3 + 4 * na);
                check($sformatf("contend%0d_rdata", na), rd_of(0, na % 2), mem_rd(0, (na % 2 == 0) ? 18'h00040 : 18'h00041));
                na++;
            end
        end
        check("contend_count", na, 4);
        set_req(0, 0, 1'b0);
        set_req(0, 1, 1'b0);
        tick();

        // Reset in the middle of the write pulse
        drive(0, 0, 1'b1, 1'b1, 18'h00555, 16'h9999);
        tick();
        tick();
        check("wpulse_wen_low", wen_v[0], 1'b0);
        rst_v[0] = 1'b1;
        tick();
        check("wpulse_rst_ctl", {cen_v[0], oen_v[0], wen_v[0], doe_v[0]}, 4'b1110);
        check("wpulse_rst_ack", ack0_v[0], 1'b0);
        check("wpulse_rst_addr", saddr_v[0], 18'h0);
        rst_v[0] = 1'b0;
        set_req(0, 0, 1'b0);
        oack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            oack |= ack0_v[0] | ack1_v[0];
        end
        check("wpulse_rst_noack", oack, 1'b0);
        vr = vec_t'{0, 0, 0, 18'h00777, 16'h0000, 1, 16'h4321, 3, 16'h4321, 8'h06, 8'h00, 8'h00, 8'h06};
        run_vec(vr, "post_rst_read");

        // Port 1 changes addr/data after grant and drops req before ack
        drive(0, 1, 1'b1, 1'b1, 18'h00ABC, 16'h5A5A);
        tick();
        drive(0, 1, 1'b1, 1'b1, 18'h00DEF, 16'hFFFF);
        tick();
        set_req(0, 1, 1'b0);
        lat = -1;
        for (int k = 3; k <= 12 && lat < 0; k++) begin
            tick();
            if (ack1_v[0]) lat = k;
        end
        check("late_change_lat", lat, 4);
        check("late_change_mem", mem_rd(0, 18'h00ABC), 16'h5A5A);
        check("late_change_stray", mem.exists(key(0, 18'h00DEF)), 1'b0);
        tick();

        // Random traffic on both instances against a transaction-level model
        do_reset(1'b0);
        ref_mem = mem;
        for (int d = 0; d < 2; d++) begin
            last_g[d] = 1; busy[d] = 0; idle_at[d] = 0; ack_at[d] = 0; own[d] = 0;
            for (int p = 0; p < 2; p++) begin
                pend[d][p] = 0; exp_rd[d][p] = '0;
                pwe[d][p] = 0; paddr[d][p] = '0; pdata[d][p] = '0;
            end
        end
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!pend[d][p] && $urandom_range(0, 2) == 0) begin
                        pend[d][p]  = 1;
                        pwe[d][p]   = 1'($urandom_range(0, 1));
                        paddr[d][p] = 18'($urandom_range(0, 31));
                        if ($urandom_range(0, 3) == 0) paddr[d][p] |= 18'h3FFE0;
                        pdata[d][p] = 16'($urandom);
                    end
                    if (busy[d] && own[d] == p)
                        drive(d, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 18'($urandom), 16'($urandom));
                    else
                        drive(d, p, pend[d][p], pwe[d][p], paddr[d][p], pdata[d][p]);
                end
                if (!busy[d] && cyc >= idle_at[d] && (pend[d][0] || pend[d][1])) begin
                    if (pend[d][0] && pend[d][1]) pk = (last_g[d] == 1) ? 0 : 1;
                    else                          pk = pend[d][1] ? 1 : 0;
                    last_g[d]  = pk;
                    own[d]     = pk;
                    busy[d]    = 1;
                    m_we[d]    = pwe[d][pk];
                    m_addr[d]  = paddr[d][pk];
                    m_data[d]  = pdata[d][pk];
                    ack_at[d]  = cyc + (m_we[d] ? ((d == 0 ? 1 : WR_B) + 3) : ((d == 0 ? 1 : RD_B) + 2));
                    idle_at[d] = ack_at[d] + 1;
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                done = busy[d] && (ack_at[d] == cyc + 1);
                e0   = done && own[d] == 0;
                e1   = done && own[d] == 1;
                if (done) begin
                    if (m_we[d]) ref_mem[key(d, m_addr[d])] = m_data[d];
                    else         exp_rd[d][own[d]] = ref_rd(d, m_addr[d]);
                    pend[d][own[d]] = 0;
                    busy[d]         = 0;
                end
                check(d == 0 ? "rand_a" : "rand_b",
                      {ack0_v[d], ack1_v[d], rdata0_v[d], rdata1_v[d]},
                      {e0, e1, exp_rd[d][0], exp_rd[d][1]});
            end
        end

        bad = 0;
        foreach (ref_mem[k]) if (!mem.exists(k) || mem[k] !== ref_mem[k]) bad++;
        foreach (mem[k]) if (!ref_mem.exists(k)) bad++;
        check("mem_final", bad, 0);
        check("protocol", proto_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
